digit_scan_ctrl: RTL and testbench



---
 rtl/digit_scan_ctrl_pkg.sv | 29 ++
 rtl/digit_scan_ctrl_dec3to8_n.sv | 15 +
 rtl/digit_scan_ctrl.sv | 107 ++++++++++
 tb/tb_digit_scan_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and constants for the digit scan controller.
// Includes the circular "next lit digit" search used by the DIGIT_SKIP_EN build.
package digit_scan_ctrl_pkg;

  localparam int NUM_DIG = 8;
  localparam int SEL_W   = 3;

  localparam logic [NUM_DIG-1:0] Y_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } scan_state_t;

  // Walks offsets from far to near so the nearest enabled index above cur wins.
  // Offset NUM_DIG lands back on cur, so a lone enabled digit returns itself.
  // With no digit enabled, cur is returned unchanged.
  function automatic logic [SEL_W-1:0] next_lit(input logic [SEL_W-1:0]   cur,
                                                input logic [NUM_DIG-1:0] mask);
    logic [SEL_W-1:0] idx;
    next_lit = cur;
    for (int i = NUM_DIG; i >= 1; i--) begin
      idx = cur + SEL_W'(i);
      if (mask[idx]) next_lit = idx;
    end
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_dec3to8_n.sv
// Combinational 3-to-8 decoder with active-low one-hot output.
// When en is low, every output is high.
module dec3to8_n
  import digit_scan_ctrl_pkg::*;
(
  input  logic               en,
  input  logic [SEL_W-1:0]   idx,
  output logic [NUM_DIG-1:0] y_n
);

  always_comb begin
    y_n = en ? ~(NUM_DIG'(1) << idx) : Y_OFF;
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller that alternates a dwell period and a blanking gap.
// Build option DIGIT_SKIP_EN: digits whose mask bit is 0 are skipped instead of held dark.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 16,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_DIG-1:0] dig_mask,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_DIG-1:0] y,
  output logic               blank,
  output logic               frame
);

  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LD  = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit               HAS_BLANK = (BLANK_CYC > 0);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] adv_sel;
  logic [SEL_W-1:0] start_sel;
  logic             adv_frame;
  logic             dig_en;

`ifdef DIGIT_SKIP_EN
  // A wrap is any advance that does not move upward; an all-zero mask freezes sel.
  always_comb begin
    adv_sel   = next_lit(sel, dig_mask);
    adv_frame = (dig_mask != '0) && (adv_sel <= sel);
    start_sel = (dig_mask == '0) ? '0 : next_lit(SEL_W'(NUM_DIG - 1), dig_mask);
  end
`else
  always_comb begin
    adv_sel   = sel + SEL_W'(1);
    adv_frame = (sel == SEL_W'(NUM_DIG - 1));
    start_sel = '0;
  end
`endif

  // Dropping en abandons the current slot; frame is held high only on the first cycle after a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
      frame <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
      frame <= 1'b0;
    end else begin
      frame <= 1'b0;
      case (state)
        IDLE: begin
          state <= ACTIVE;
          sel   <= start_sel;
          cnt   <= DWELL_LD;
        end
        ACTIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (HAS_BLANK) begin
            state <= BLANK;
            cnt   <= BLANK_LD;
          end else begin
            state <= ACTIVE;
            sel   <= adv_sel;
            cnt   <= DWELL_LD;
            frame <= adv_frame;
          end
        end
        BLANK: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= ACTIVE;
            sel   <= adv_sel;
            cnt   <= DWELL_LD;
            frame <= adv_frame;
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign dig_en = (state == ACTIVE) && dig_mask[sel];
  assign blank  = (state != ACTIVE);

  dec3to8_n u_dec (
    .en  (dig_en),
    .idx (sel),
    .y_n (y)
  );

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: a 4/2 dwell/blank instance and a 1/0 instance.
// The DIGIT_SKIP_EN build also runs the skip-mode sequence.
module tb_digit_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en_a, en_b;
  logic [7:0] mask_a, mask_b;
  logic [2:0] sel_a, sel_b;
  logic [7:0] y_a, y_b;
  logic       blank_a, blank_b;
  logic       frame_a, frame_b;

  int total = 0;
  int bad   = 0;

`ifdef DIGIT_SKIP_EN
  localparam logic [7:0] MASK_F2 = 8'hFF;
`else
  localparam logic [7:0] MASK_F2 = 8'hF0;
`endif

  digit_scan_ctrl #(.DWELL_CYC(4), .BLANK_CYC(2), .CNT_W(16)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_a),
    .dig_mask (mask_a),
    .sel      (sel_a),
    .y        (y_a),
    .blank    (blank_a),
    .frame    (frame_a)
  );

  digit_scan_ctrl #(.DWELL_CYC(1), .BLANK_CYC(0), .CNT_W(4)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_b),
    .dig_mask (mask_b),
    .sel      (sel_b),
    .y        (y_b),
    .blank    (blank_b),
    .frame    (frame_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] y_e, input logic [2:0] sel_e,
                         input logic blank_e, input logic frame_e);
    check_output({tag, ".y"},     y_a,            y_e);
    check_output({tag, ".sel"},   {5'd0, sel_a},  {5'd0, sel_e});
    check_output({tag, ".blank"}, {7'd0, blank_a}, {7'd0, blank_e});
    check_output({tag, ".frame"}, {7'd0, frame_a}, {7'd0, frame_e});
  endtask

  initial begin
    logic [7:0] one;
    logic [7:0] exp_y;
    logic [7:0] cur_mask;
    int         dig;
    one    = 8'b1;
    rst_n  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    mask_a = 8'hFF;
    mask_b = 8'hFF;

    #2;
    check_a("reset", 8'hFF, 3'd0, 1'b1, 1'b0);
    check_output("reset_b.y", y_b, 8'hFF);
    #10;
    rst_n = 1'b1;
    tick();
    check_a("idle", 8'hFF, 3'd0, 1'b1, 1'b0);

    // One-cycle dwell, no blanking: a new digit every cycle, frame on the wrap
    en_b = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_y = ~(one << ((k - 1) % 8));
      check_output($sformatf("fast%0d.y", k), y_b, exp_y);
      check_output($sformatf("fast%0d.sel", k), {5'd0, sel_b}, 8'((k - 1) % 8));
      check_output($sformatf("fast%0d.blank", k), {7'd0, blank_b}, 8'd0);
      check_output($sformatf("fast%0d.frame", k), {7'd0, frame_b}, (k == 9) ? 8'd1 : 8'd0);
    end
    en_b = 1'b0;
    tick();
    check_output("fast_off.y", y_b, 8'hFF);
    check_output("fast_off.blank", {7'd0, blank_b}, 8'd1);

    // Three frames of 4 dwell + 2 blank per digit; the third frame uses a partial mask
    en_a = 1'b1;
    for (int f = 0; f < 3; f++) begin
      cur_mask = (f == 2) ? MASK_F2 : 8'hFF;
      mask_a   = cur_mask;
      for (int d = 0; d < 8; d++) begin
        for (int c = 0; c < 6; c++) begin
          tick();
          exp_y = (c < 4 && cur_mask[d]) ? ~(one << d) : 8'hFF;
          check_a($sformatf("f%0d_d%0d_c%0d", f, d, c), exp_y, 3'(d), (c >= 4),
                  (f > 0 && d == 0 && c == 0));
        end
      end
    end
    mask_a = 8'hFF;
    tick();
    check_a("frame3_start", 8'hFE, 3'd0, 1'b0, 1'b1);

    for (int k = 0; k < 31; k++) tick();
    check_a("dwell5", 8'hDF, 3'd5, 1'b0, 1'b0);
    en_a = 1'b0;
    tick();
    check_a("en_drop", 8'hFF, 3'd0, 1'b1, 1'b0);
    tick();
    check_a("en_drop_hold", 8'hFF, 3'd0, 1'b1, 1'b0);
    en_a = 1'b1;
    tick();
    check_a("restart", 8'hFE, 3'd0, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) tick();
    check_a("pre_reset", 8'hFF, 3'd1, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_a("async_reset", 8'hFF, 3'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    check_a("post_reset", 8'hFE, 3'd0, 1'b0, 1'b0);

`ifdef DIGIT_SKIP_EN
    en_a = 1'b0;
    tick();
    mask_a = 8'b1000_0010;
    en_a   = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 2; s++) begin
        for (int c = 0; c < 6; c++) begin
          tick();
          dig   = (s == 1) ? 7 : 1;
          exp_y = (c < 4) ? ~(one << dig) : 8'hFF;
          check_a($sformatf("skip_r%0d_s%0d_c%0d", r, s, c), exp_y, 3'(dig), (c >= 4),
                  (r > 0 && s == 0 && c == 0));
        end
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
